// File: rtl/ccu_snoop_arbiter.sv
// Two-requester snoop arbiter: round-robin AC grant, with CR and CD responses
// steered back to the originator through in-order index FIFOs.

module ccu_snoop_order_fifo #(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            push_idx_i,
  input  logic            pop_i,
  output logic            head_o,
  output logic [CntW-1:0] count_o
);
  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;

  // Registered occupancy: an entry pushed this cycle is not visible at the head
  // until the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_idx_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + PtrW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CntW'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

module ccu_snoop_arbiter #(
  parameter  int unsigned AddrWidth   = 64,
  parameter  int unsigned CdDataWidth = 64,
  parameter  int unsigned MaskWidth   = 4,
  parameter  int unsigned MaxTrans    = 4,
  localparam int unsigned CntW        = $clog2(MaxTrans) + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // AC from requesters
  input  logic [1:0]                       req_ac_valid_i,
  output logic [1:0]                       req_ac_ready_o,
  input  logic [1:0][AddrWidth-1:0]        req_ac_addr_i,
  input  logic [1:0][3:0]                  req_ac_snoop_i,
  input  logic [1:0][2:0]                  req_ac_prot_i,
  input  logic [1:0][MaskWidth-1:0]        req_mask_i,
  // AC to snooped masters
  output logic                             snp_ac_valid_o,
  input  logic                             snp_ac_ready_i,
  output logic [AddrWidth-1:0]             snp_ac_addr_o,
  output logic [3:0]                       snp_ac_snoop_o,
  output logic [2:0]                       snp_ac_prot_o,
  output logic [MaskWidth-1:0]             snp_mask_o,
  // CR
  input  logic                             snp_cr_valid_i,
  output logic                             snp_cr_ready_o,
  input  logic [4:0]                       snp_cr_resp_i,
  output logic [1:0]                       req_cr_valid_o,
  input  logic [1:0]                       req_cr_ready_i,
  output logic [4:0]                       req_cr_resp_o,
  // CD
  input  logic                             snp_cd_valid_i,
  output logic                             snp_cd_ready_o,
  input  logic [CdDataWidth-1:0]           snp_cd_data_i,
  input  logic                             snp_cd_last_i,
  output logic [1:0]                       req_cd_valid_o,
  input  logic [1:0]                       req_cd_ready_i,
  output logic [CdDataWidth-1:0]           req_cd_data_o,
  output logic                             req_cd_last_o,
  output logic [CntW-1:0]                  outstanding_o
);

  logic            prio_q, lock_q, lock_idx_q;
  logic            gnt, ac_en, ac_hs;
  logic            cr_head, cd_head;
  logic [CntW-1:0] cr_cnt, cd_cnt;
  logic            cr_full, cr_empty, cd_full, cd_empty;
  logic            cr_stall, cr_hs, cd_push, cd_pop;

  assign cr_full  = (cr_cnt == CntW'(MaxTrans));
  assign cr_empty = (cr_cnt == '0);
  assign cd_full  = (cd_cnt == CntW'(MaxTrans));
  assign cd_empty = (cd_cnt == '0);

  // ---------------- AC arbitration ----------------
  // A pending (valid, not ready) grant is locked so the payload stays stable.
  always_comb begin
    if (lock_q)                gnt = lock_idx_q;
    else if (&req_ac_valid_i)  gnt = prio_q;
    else                       gnt = req_ac_valid_i[1];
  end

  // rst_ni gating keeps the combinational AC path quiet while reset is held.
  assign ac_en          = rst_ni & ~cr_full;
  assign snp_ac_valid_o = ac_en & req_ac_valid_i[gnt];
  assign ac_hs          = snp_ac_valid_o & snp_ac_ready_i;

  always_comb begin
    req_ac_ready_o      = '0;
    req_ac_ready_o[gnt] = ac_en & snp_ac_ready_i & req_ac_valid_i[gnt];
  end

  assign snp_ac_addr_o  = req_ac_addr_i[gnt];
  assign snp_ac_snoop_o = req_ac_snoop_i[gnt];
  assign snp_ac_prot_o  = req_ac_prot_i[gnt];
  assign snp_mask_o     = req_mask_i[gnt];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
    end else begin
      if (ac_hs) prio_q <= ~gnt;
      lock_q     <= snp_ac_valid_o & ~snp_ac_ready_i;
      lock_idx_q <= gnt;
    end
  end

  // ---------------- CR routing ----------------
  ccu_snoop_order_fifo #(.Depth(MaxTrans)) u_cr_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (ac_hs),
    .push_idx_i (gnt),
    .pop_i      (cr_hs),
    .head_o     (cr_head),
    .count_o    (cr_cnt)
  );

  // A data-carrying response needs a CD slot; hold it off while none is free.
  assign cr_stall       = snp_cr_resp_i[0] & cd_full;
  assign snp_cr_ready_o = ~cr_empty & ~cr_stall & req_cr_ready_i[cr_head];
  assign cr_hs          = snp_cr_valid_i & snp_cr_ready_o;
  assign cd_push        = cr_hs & snp_cr_resp_i[0];
  assign req_cr_resp_o  = snp_cr_resp_i;

  always_comb begin
    req_cr_valid_o          = '0;
    req_cr_valid_o[cr_head] = snp_cr_valid_i & ~cr_empty & ~cr_stall;
  end

  // ---------------- CD routing ----------------
  ccu_snoop_order_fifo #(.Depth(MaxTrans)) u_cd_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (cd_push),
    .push_idx_i (cr_head),
    .pop_i      (cd_pop),
    .head_o     (cd_head),
    .count_o    (cd_cnt)
  );

  assign snp_cd_ready_o = ~cd_empty & req_cd_ready_i[cd_head];
  assign cd_pop         = snp_cd_valid_i & snp_cd_ready_o & snp_cd_last_i;
  assign req_cd_data_o  = snp_cd_data_i;
  assign req_cd_last_o  = snp_cd_last_i;

  always_comb begin
    req_cd_valid_o          = '0;
    req_cd_valid_o[cd_head] = snp_cd_valid_i & ~cd_empty;
  end

  assign outstanding_o = cr_cnt;

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter: arbitration, ordering, stalls and reset.

module tb_ccu_snoop_arbiter;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_ac_valid, req_ac_ready;
  logic [1:0][63:0]  req_ac_addr;
  logic [1:0][3:0]   req_ac_snoop;
  logic [1:0][2:0]   req_ac_prot;
  logic [1:0][3:0]   req_mask;
  logic              snp_ac_valid, snp_ac_ready;
  logic [63:0]       snp_ac_addr;
  logic [3:0]        snp_ac_snoop;
  logic [2:0]        snp_ac_prot;
  logic [3:0]        snp_mask;
  logic              snp_cr_valid, snp_cr_ready;
  logic [4:0]        snp_cr_resp, req_cr_resp;
  logic [1:0]        req_cr_valid, req_cr_ready;
  logic              snp_cd_valid, snp_cd_ready, snp_cd_last;
  logic [63:0]       snp_cd_data, req_cd_data;
  logic [1:0]        req_cd_valid, req_cd_ready;
  logic              req_cd_last;
  logic [2:0]        outstanding;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] A0 = 64'hA000_0000_0000_1000;
  localparam logic [63:0] A1 = 64'hB100_0000_0000_2040;

  always #5 clk = ~clk;

  ccu_snoop_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_ac_valid_i (req_ac_valid),
    .req_ac_ready_o (req_ac_ready),
    .req_ac_addr_i  (req_ac_addr),
    .req_ac_snoop_i (req_ac_snoop),
    .req_ac_prot_i  (req_ac_prot),
    .req_mask_i     (req_mask),
    .snp_ac_valid_o (snp_ac_valid),
    .snp_ac_ready_i (snp_ac_ready),
    .snp_ac_addr_o  (snp_ac_addr),
    .snp_ac_snoop_o (snp_ac_snoop),
    .snp_ac_prot_o  (snp_ac_prot),
    .snp_mask_o     (snp_mask),
    .snp_cr_valid_i (snp_cr_valid),
    .snp_cr_ready_o (snp_cr_ready),
    .snp_cr_resp_i  (snp_cr_resp),
    .req_cr_valid_o (req_cr_valid),
    .req_cr_ready_i (req_cr_ready),
    .req_cr_resp_o  (req_cr_resp),
    .snp_cd_valid_i (snp_cd_valid),
    .snp_cd_ready_o (snp_cd_ready),
    .snp_cd_data_i  (snp_cd_data),
    .snp_cd_last_i  (snp_cd_last),
    .req_cd_valid_o (req_cd_valid),
    .req_cd_ready_i (req_cd_ready),
    .req_cd_data_o  (req_cd_data),
    .req_cd_last_o  (req_cd_last),
    .outstanding_o  (outstanding)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_ac_valid = 2'b11; snp_ac_ready = 1'b1;
    snp_cr_valid = 1'b1; snp_cd_valid = 1'b1; req_cr_ready = 2'b11; req_cd_ready = 2'b11;
    #1;
    n_chk++; if (snp_ac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_snp_ac_valid got %b exp 0", snp_ac_valid); end
    n_chk++; if (req_ac_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ac_ready got %b exp 00", req_ac_ready); end
    n_chk++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_chk++; if (snp_cr_ready !== 1'b0 || req_cr_valid !== 2'b00) begin n_fail++; $display("FAIL reset_cr got rdy=%b vld=%b exp 0/00", snp_cr_ready, req_cr_valid); end
    n_chk++; if (snp_cd_ready !== 1'b0 || req_cd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_cd got rdy=%b vld=%b exp 0/00", snp_cd_ready, req_cd_valid); end
    tick(); tick();
    req_ac_valid = 2'b00; snp_cr_valid = 1'b0; snp_cd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  // Both requesters valid: grants alternate until the order FIFO is full, then drain.
  task automatic test_rr_fill();
    logic [1:0] e;
    req_ac_valid = 2'b11; snp_ac_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = i[0] ? 2'b10 : 2'b01;
      n_chk++; if (snp_ac_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b exp 1", i, snp_ac_valid); end
      n_chk++; if (req_ac_ready !== e) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ac_ready, e); end
      n_chk++; if (snp_ac_addr !== (i[0] ? A1 : A0)) begin n_fail++; $display("FAIL rr_addr[%0d] got %h exp %h", i, snp_ac_addr, i[0] ? A1 : A0); end
      n_chk++; if (snp_ac_snoop !== (i[0] ? 4'h7 : 4'h1) || snp_mask !== (i[0] ? 4'hA : 4'h5)) begin n_fail++; $display("FAIL rr_payload[%0d] got snoop=%h mask=%h", i, snp_ac_snoop, snp_mask); end
      n_chk++; if (outstanding !== 3'(i)) begin n_fail++; $display("FAIL rr_outstanding[%0d] got %0d exp %0d", i, outstanding, i); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (snp_ac_valid !== 1'b0 || req_ac_ready !== 2'b00) begin n_fail++; $display("FAIL full_block[%0d] got vld=%b rdy=%b exp 0/00", i, snp_ac_valid, req_ac_ready); end
      n_chk++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding[%0d] got %0d exp 4", i, outstanding); end
      tick();
    end
    req_ac_valid = 2'b00; snp_cr_valid = 1'b1; snp_cr_resp = 5'h00; req_cr_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = i[0] ? 2'b10 : 2'b01;
      n_chk++; if (req_cr_valid !== e || snp_cr_ready !== 1'b1) begin n_fail++; $display("FAIL drain_cr[%0d] got vld=%b rdy=%b exp %b/1", i, req_cr_valid, snp_cr_ready, e); end
      n_chk++; if (outstanding !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_outstanding[%0d] got %0d exp %0d", i, outstanding, 4 - i); end
      tick();
    end
    snp_cr_valid = 1'b0; #1;
    n_chk++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL drain_end got %0d exp 0", outstanding); end
    tick();
  endtask

  // Pending grant to requester 1 must survive requester 0 raising valid.
  task automatic test_hold();
    req_ac_valid = 2'b10; snp_ac_ready = 1'b0; #1;
    n_chk++; if (snp_ac_valid !== 1'b1 || snp_ac_addr !== A1) begin n_fail++; $display("FAIL hold_first got vld=%b addr=%h exp 1/%h", snp_ac_valid, snp_ac_addr, A1); end
    tick();
    req_ac_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (snp_ac_addr !== A1 || snp_ac_valid !== 1'b1) begin n_fail++; $display("FAIL hold_stable[%0d] got vld=%b addr=%h exp 1/%h", i, snp_ac_valid, snp_ac_addr, A1); end
      n_chk++; if (req_ac_ready !== 2'b00) begin n_fail++; $display("FAIL hold_ready[%0d] got %b exp 00", i, req_ac_ready); end
      tick();
    end
    snp_ac_ready = 1'b1; #1;
    n_chk++; if (req_ac_ready !== 2'b10 || snp_ac_addr !== A1) begin n_fail++; $display("FAIL hold_release got rdy=%b addr=%h exp 10/%h", req_ac_ready, snp_ac_addr, A1); end
    tick();
    n_chk++; if (req_ac_ready !== 2'b01 || snp_ac_addr !== A0) begin n_fail++; $display("FAIL hold_next got rdy=%b addr=%h exp 01/%h", req_ac_ready, snp_ac_addr, A0); end
    tick();
    req_ac_valid = 2'b00; #1;
    n_chk++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL hold_outstanding got %0d exp 2", outstanding); end
    tick();
  endtask

  // AC push and CR pop in one cycle with 2 outstanding (order 1,0).
  task automatic test_simul();
    req_ac_valid = 2'b01; snp_ac_ready = 1'b1; snp_cr_valid = 1'b1; snp_cr_resp = 5'h00; req_cr_ready = 2'b11;
    #1;
    n_chk++; if (snp_ac_valid !== 1'b1 || snp_cr_ready !== 1'b1 || req_cr_valid !== 2'b10) begin n_fail++; $display("FAIL simul_hs got acv=%b crr=%b crv=%b exp 1/1/10", snp_ac_valid, snp_cr_ready, req_cr_valid); end
    tick();
    req_ac_valid = 2'b00; #1;
    n_chk++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL simul_outstanding got %0d exp 2", outstanding); end
    n_chk++; if (req_cr_valid !== 2'b01) begin n_fail++; $display("FAIL simul_head got %b exp 01", req_cr_valid); end
    tick();
    n_chk++; if (req_cr_valid !== 2'b01 || outstanding !== 3'd1) begin n_fail++; $display("FAIL simul_pushed got vld=%b out=%0d exp 01/1", req_cr_valid, outstanding); end
    tick();
    snp_cr_valid = 1'b0; #1;
    n_chk++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL simul_end got %0d exp 0", outstanding); end
    tick();
  endtask

  // Issue req0, req1, req0; resps 01,00,01; two CD bursts both to req0.
  task automatic test_route();
    req_ac_valid = 2'b01; snp_ac_ready = 1'b1; snp_cr_valid = 1'b1; snp_cr_resp = 5'h00; req_cr_ready = 2'b11;
    #1;
    n_chk++; if (req_ac_ready !== 2'b01) begin n_fail++; $display("FAIL route_ac0 got %b exp 01", req_ac_ready); end
    n_chk++; if (snp_cr_ready !== 1'b0 || req_cr_valid !== 2'b00) begin n_fail++; $display("FAIL route_no_fallthru got rdy=%b vld=%b exp 0/00", snp_cr_ready, req_cr_valid); end
    tick();
    snp_cr_valid = 1'b0; req_ac_valid = 2'b10; #1;
    n_chk++; if (req_ac_ready !== 2'b10) begin n_fail++; $display("FAIL route_ac1 got %b exp 10", req_ac_ready); end
    tick();
    req_ac_valid = 2'b01; tick();
    req_ac_valid = 2'b00;
    snp_cr_valid = 1'b1; snp_cr_resp = 5'h01; snp_cd_valid = 1'b1; snp_cd_last = 1'b0;
    snp_cd_data = 64'hDEAD; req_cd_ready = 2'b11; #1;
    n_chk++; if (req_cr_valid !== 2'b01 || req_cr_resp !== 5'h01) begin n_fail++; $display("FAIL route_cr0 got vld=%b resp=%h exp 01/01", req_cr_valid, req_cr_resp); end
    n_chk++; if (snp_cd_ready !== 1'b0 || req_cd_valid !== 2'b00) begin n_fail++; $display("FAIL route_cd_wait got rdy=%b vld=%b exp 0/00", snp_cd_ready, req_cd_valid); end
    tick();
    snp_cd_valid = 1'b0; snp_cr_resp = 5'h00; #1;
    n_chk++; if (req_cr_valid !== 2'b10 || req_cr_resp !== 5'h00) begin n_fail++; $display("FAIL route_cr1 got vld=%b resp=%h exp 10/00", req_cr_valid, req_cr_resp); end
    tick();
    snp_cr_resp = 5'h01; #1;
    n_chk++; if (req_cr_valid !== 2'b01) begin n_fail++; $display("FAIL route_cr2 got %b exp 01", req_cr_valid); end
    tick();
    snp_cr_valid = 1'b0; snp_cd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      snp_cd_data = 64'hD000 + 64'(k); snp_cd_last = (k % 4 == 3); #1;
      n_chk++; if (req_cd_valid !== 2'b01 || snp_cd_ready !== 1'b1) begin n_fail++; $display("FAIL route_cd[%0d] got vld=%b rdy=%b exp 01/1", k, req_cd_valid, snp_cd_ready); end
      n_chk++; if (req_cd_data !== 64'hD000 + 64'(k) || req_cd_last !== (k % 4 == 3)) begin n_fail++; $display("FAIL route_cd_data[%0d] got %h/%b", k, req_cd_data, req_cd_last); end
      tick();
    end
    snp_cd_last = 1'b0; #1;
    n_chk++; if (snp_cd_ready !== 1'b0 || req_cd_valid !== 2'b00) begin n_fail++; $display("FAIL route_cd_empty got rdy=%b vld=%b exp 0/00", snp_cd_ready, req_cd_valid); end
    snp_cd_valid = 1'b0;
    n_chk++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL route_outstanding got %0d exp 0", outstanding); end
    tick();
  endtask

  // Full CD FIFO stalls a data-carrying CR until a last beat retires.
  task automatic test_cd_full();
    req_ac_valid = 2'b01; snp_ac_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    req_ac_valid = 2'b00;
    snp_cr_valid = 1'b1; snp_cr_resp = 5'h01; req_cr_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (snp_cr_ready !== 1'b1) begin n_fail++; $display("FAIL cdfull_fill[%0d] got %b exp 1", i, snp_cr_ready); end
      tick();
    end
    req_ac_valid = 2'b01; tick();
    req_ac_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (snp_cr_ready !== 1'b0 || outstanding !== 3'd1) begin n_fail++; $display("FAIL cdfull_stall[%0d] got rdy=%b out=%0d exp 0/1", i, snp_cr_ready, outstanding); end
      tick();
    end
    snp_cd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      snp_cd_last = (k == 3); #1;
      n_chk++; if (snp_cr_ready !== 1'b0) begin n_fail++; $display("FAIL cdfull_beat[%0d] got %b exp 0", k, snp_cr_ready); end
      tick();
    end
    snp_cd_valid = 1'b0; snp_cd_last = 1'b0; #1;
    n_chk++; if (snp_cr_ready !== 1'b1) begin n_fail++; $display("FAIL cdfull_release got %b exp 1", snp_cr_ready); end
    tick();
    snp_cr_valid = 1'b0; #1;
    n_chk++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL cdfull_outstanding got %0d exp 0", outstanding); end
    snp_cd_valid = 1'b1; snp_cd_last = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    #1;
    n_chk++; if (snp_cd_ready !== 1'b0) begin n_fail++; $display("FAIL cdfull_drained got %b exp 0", snp_cd_ready); end
    snp_cd_valid = 1'b0; snp_cd_last = 1'b0;
    tick();
  endtask

  // Reset with 3 outstanding discards order state and the priority pointer.
  task automatic test_reset_mid();
    req_ac_valid = 2'b01; snp_ac_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    req_ac_valid = 2'b11; #1;
    n_chk++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 3", outstanding); end
    rst_n = 1'b0; #1;
    n_chk++; if (outstanding !== 3'd0 || snp_ac_valid !== 1'b0 || req_cr_valid !== 2'b00 || req_cd_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_clear got out=%0d acv=%b crv=%b cdv=%b", outstanding, snp_ac_valid, req_cr_valid, req_cd_valid); end
    tick();
    rst_n = 1'b1; req_ac_valid = 2'b00; tick();
    snp_cr_valid = 1'b1; #1;
    n_chk++; if (snp_cr_ready !== 1'b0 || req_cr_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_cr got rdy=%b vld=%b exp 0/00", snp_cr_ready, req_cr_valid); end
    snp_cr_valid = 1'b0; req_ac_valid = 2'b11; snp_ac_ready = 1'b0; #1;
    n_chk++; if (snp_ac_valid !== 1'b1 || snp_ac_addr !== A0) begin n_fail++; $display("FAIL rstmid_prio got vld=%b addr=%h exp 1/%h", snp_ac_valid, snp_ac_addr, A0); end
    req_ac_valid = 2'b00;
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    req_ac_valid = '0; snp_ac_ready = 1'b0;
    req_ac_addr[0] = A0; req_ac_addr[1] = A1;
    req_ac_snoop[0] = 4'h1; req_ac_snoop[1] = 4'h7;
    req_ac_prot[0] = 3'h2; req_ac_prot[1] = 3'h5;
    req_mask[0] = 4'h5; req_mask[1] = 4'hA;
    snp_cr_valid = 1'b0; snp_cr_resp = '0; req_cr_ready = '0;
    snp_cd_valid = 1'b0; snp_cd_data = '0; snp_cd_last = 1'b0; req_cd_ready = '0;
    #2;
    test_reset();
    test_rr_fill();
    test_hold();
    test_simul();
    test_route();
    test_cd_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ccu_snoop_arbiter.md
CCU_SNOOP_ARBITER -- requirements
Module: ccu_snoop_arbiter

Interface
REQ-001 Parameter AddrWidth, default 64, AC address width.
REQ-002 Parameter CdDataWidth, default 64, CD data width.
REQ-003 Parameter MaskWidth, default 4, domain mask width (one bit per snooped master).
REQ-004 Parameter MaxTrans, default 4, max outstanding snoops; power of two, >= 2.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port clk_i, input, 1, clock.
REQ-007 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 Ports req_ac_valid_i[1:0], input, 2, AC valid per requester (bit 0 read-snoop ctrl, bit 1 write-snoop ctrl).
REQ-009 Ports req_ac_ready_o[1:0], output, 2, AC ready per requester.
REQ-010 Ports req_ac_addr_i[1:0], input, 2xAddrWidth; req_ac_snoop_i[1:0], input, 2x4; req_ac_prot_i[1:0], input, 2x3; req_mask_i[1:0], input, 2xMaskWidth.
REQ-011 Ports snp_ac_valid_o / snp_ac_ready_i, 1 each; snp_ac_addr_o AddrWidth, snp_ac_snoop_o 4, snp_ac_prot_o 3, snp_mask_o MaskWidth, all outputs except ready.
REQ-012 Ports snp_cr_valid_i, input, 1; snp_cr_ready_o, output, 1; snp_cr_resp_i, input, 5 (bit 0 DataTransfer).
REQ-013 Ports req_cr_valid_o[1:0], output, 2; req_cr_ready_i[1:0], input, 2; req_cr_resp_o, output, 5, shared.
REQ-014 Ports snp_cd_valid_i, input, 1; snp_cd_ready_o, output, 1; snp_cd_data_i, input, CdDataWidth; snp_cd_last_i, input, 1.
REQ-015 Ports req_cd_valid_o[1:0], output, 2; req_cd_ready_i[1:0], input, 2; req_cd_data_o CdDataWidth, req_cd_last_o 1, outputs, shared.
REQ-016 Port outstanding_o, output, $clog2(MaxTrans)+1, snoops issued whose CR not yet accepted.

Function
REQ-017 AC arbitration SHALL be round-robin between valid requesters; priority pointer flips to the other requester after each AC handshake.
REQ-018 Once snp_ac_valid_o is asserted, the grant SHALL be held and payload stable until snp_ac_ready_i; no re-arbitration while pending.
REQ-019 snp_ac_valid_o SHALL be low when the CR order FIFO is full (MaxTrans entries); ready_o of losing/blocked requesters low.
REQ-020 AC path SHALL be combinational (zero latency): snp_ac_* = granted requester payload, req_ac_ready_o[g] = snp_ac_ready_i & ~full.
REQ-021 On AC handshake the granted index SHALL be pushed into the CR order FIFO (depth MaxTrans).
REQ-022 CR routing: with CR FIFO non-empty, req_cr_valid_o[head] = snp_cr_valid_i, snp_cr_ready_o = req_cr_ready_i[head]; CR FIFO empty -> snp_cr_ready_o = 0, all req_cr_valid_o = 0.
REQ-023 On CR handshake: pop CR FIFO; if resp[0]=1 push head index into CD order FIFO (depth MaxTrans) in the same cycle.
REQ-024 CR SHALL stall (snp_cr_ready_o = 0) when resp[0]=1 and the CD FIFO is full.
REQ-025 CD routing: CD FIFO non-empty -> req_cd_valid_o[head] = snp_cd_valid_i, snp_cd_ready_o = req_cd_ready_i[head]; pop on beat handshake with snp_cd_last_i=1; empty -> snp_cd_ready_o = 0.
REQ-026 CD beat arriving in the same cycle its CR is accepted SHALL wait one cycle (CD FIFO is not fall-through).
REQ-027 Simultaneous AC push and CR pop SHALL leave outstanding_o unchanged; push only +1, pop only -1; never exceeds MaxTrans nor underflows.
REQ-028 CR SHALL NOT be accepted for a snoop whose AC handshake completes in the same cycle (CR FIFO is not fall-through).
REQ-029 Payload outputs req_cr_resp_o, req_cd_data_o, req_cd_last_o SHALL pass the snoop-side values unmodified to both requesters.

Reset
REQ-030 During reset: all valid/ready outputs 0, outstanding_o = 0, both FIFOs empty, priority pointer = requester 0.
REQ-031 Reset mid-transaction SHALL discard all order state; first AC after reset goes to requester 0 if both valid.

Verification
REQ-032 Both requesters valid continuously, snp_ac_ready_i=1 -> grants alternate 0,1,0,1; outstanding_o counts 1..4, then snp_ac_valid_o=0 until a CR accepted.
REQ-033 AC from req1 held with snp_ac_ready_i=0 for 5 cycles while req0 raises valid -> grant stays 1, addr stable, req0 granted next.
REQ-034 Issue req0, req1, req0; CR resps 0x01,0x00,0x01 -> CRs delivered to 0,1,0; CD bursts (4 beats, last on 4th) go to req0 then req0; req1 sees no CD valid.
REQ-035 CD FIFO full (4 entries) and CR resp 0x01 pending -> snp_cr_ready_o=0 until a CD last beat handshakes, then CR accepted next cycle.
REQ-036 AC handshake and CR handshake same cycle with outstanding_o=2 -> outstanding_o stays 2.
REQ-037 Assert rst_ni=0 with 3 outstanding -> next cycle all valids 0, outstanding_o=0; snp_cr_valid_i asserted afterwards is not accepted.
